// File: rtl/avalon_rd_wr_arbiter.sv
// avalon_rd_wr_arbiter
// Shares one Avalon-MM SDRAM agent port between two hosts. Host 0 (framebuffer
// reader) has priority, but host 1 (drawing writer) gets a forced grant after
// STARVE_LIMIT consecutive host-0 grants taken while it was waiting. Bursts are
// granted whole. Read beats go back to the host that issued the burst.
//
// Ports
//   clk, rst_n            SDRAM-domain clock, synchronous active-low reset
//   hN_*                  host N Avalon-MM port (N = 0, 1)
//   m_*                   Avalon-MM port to the SDRAM agent
//   stray_beat            one-cycle pulse when a read beat arrives that no
//                         host is waiting for (e.g. left over from a reset)
//
// state   | meaning
// IDLE    | no owner active; arbitrate and latch the winner
// CMD     | owner's command passed to the agent until accepted
// RD_DATA | waiting for the read beats of the accepted burst
// WR_DATA | passing the remaining write beats of the accepted burst
module avalon_rd_wr_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int BURST_W      = 6,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     h0_address,
  input  logic                  h0_read,
  input  logic                  h0_write,
  input  logic [DATA_W-1:0]     h0_writedata,
  input  logic [DATA_W/8-1:0]   h0_byteenable,
  input  logic [BURST_W-1:0]    h0_burstcount,
  output logic                  h0_waitrequest,
  output logic [DATA_W-1:0]     h0_readdata,
  output logic                  h0_readdatavalid,
  input  logic [ADDR_W-1:0]     h1_address,
  input  logic                  h1_read,
  input  logic                  h1_write,
  input  logic [DATA_W-1:0]     h1_writedata,
  input  logic [DATA_W/8-1:0]   h1_byteenable,
  input  logic [BURST_W-1:0]    h1_burstcount,
  output logic                  h1_waitrequest,
  output logic [DATA_W-1:0]     h1_readdata,
  output logic                  h1_readdatavalid,
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W-1:0]     m_writedata,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic [BURST_W-1:0]    m_burstcount,
  output logic                  m_read,
  output logic                  m_write,
  input  logic                  m_waitrequest,
  input  logic                  m_readdatavalid,
  input  logic [DATA_W-1:0]     m_readdata,
  output logic                  stray_beat
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, CMD, RD_DATA, WR_DATA} state_t;

  state_t               state, state_nxt;
  logic                 owner, owner_nxt;
  logic [BURST_W-1:0]   beat_cnt, beat_nxt;
  logic [STARVE_W-1:0]  starve_cnt;
  logic [ADDR_W-1:0]    addr_q, addr_nxt;
  logic [BURST_W-1:0]   bc_q, bc_nxt;

  logic                 req0, req1, grant1;
  logic                 o_read, o_write;
  logic [ADDR_W-1:0]    o_address;
  logic [DATA_W-1:0]    o_writedata;
  logic [DATA_W/8-1:0]  o_byteenable;
  logic [BURST_W-1:0]   o_burstcount, bc_eff;
  logic                 own_wait, rdv_own;

  assign req0   = h0_read | h0_write;
  assign req1   = h1_read | h1_write;
  assign grant1 = req1 & (~req0 | (starve_cnt == STARVE_MAX));

  assign o_read       = owner ? h1_read       : h0_read;
  assign o_write      = owner ? h1_write      : h0_write;
  assign o_address    = owner ? h1_address    : h0_address;
  assign o_writedata  = owner ? h1_writedata  : h0_writedata;
  assign o_byteenable = owner ? h1_byteenable : h0_byteenable;
  assign o_burstcount = owner ? h1_burstcount : h0_burstcount;

  // A burstcount of 0 is passed to the agent untouched but counted as 1 beat.
  assign bc_eff = (o_burstcount == '0) ? BURST_W'(1) : o_burstcount;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      beat_cnt   <= '0;
      starve_cnt <= '0;
      addr_q     <= '0;
      bc_q       <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_nxt;
      addr_q   <= addr_nxt;
      bc_q     <= bc_nxt;
      if (!req1) begin
        starve_cnt <= '0;
      end else if (state == IDLE) begin
        if (grant1)
          starve_cnt <= '0;
        else if (req0 && starve_cnt != STARVE_MAX)
          starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    beat_nxt     = beat_cnt;
    addr_nxt     = addr_q;
    bc_nxt       = bc_q;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_address    = o_address;
    m_burstcount = o_burstcount;
    m_writedata  = o_writedata;
    m_byteenable = o_byteenable;
    own_wait     = 1'b1;
    rdv_own      = 1'b0;
    stray_beat   = 1'b0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          owner_nxt = grant1;
          state_nxt = CMD;
        end
      end
      CMD: begin
        own_wait = m_waitrequest;
        m_read   = o_read;
        m_write  = o_write & ~o_read;   // read wins when both are raised
        if (!o_read && !o_write) begin
          state_nxt = IDLE;
        end else if (!m_waitrequest) begin
          // Address and burstcount are frozen here for the rest of a write burst.
          addr_nxt = o_address;
          bc_nxt   = o_burstcount;
          if (o_read) begin
            beat_nxt  = bc_eff;
            state_nxt = RD_DATA;
          end else begin
            beat_nxt  = bc_eff - BURST_W'(1);
            state_nxt = (bc_eff == BURST_W'(1)) ? IDLE : WR_DATA;
          end
        end
      end
      RD_DATA: begin
        if (m_readdatavalid) begin
          rdv_own  = 1'b1;
          beat_nxt = beat_cnt - BURST_W'(1);
          if (beat_cnt == BURST_W'(1))
            state_nxt = IDLE;
        end
      end
      WR_DATA: begin
        m_address    = addr_q;
        m_burstcount = bc_q;
        m_write      = o_write;
        own_wait     = m_waitrequest;
        // A host dropping write mid-burst just stalls the burst here.
        if (o_write && !m_waitrequest) begin
          beat_nxt = beat_cnt - BURST_W'(1);
          if (beat_cnt == BURST_W'(1))
            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    stray_beat = m_readdatavalid & (state != RD_DATA);

    // Hold the port quiet while reset is asserted, whatever state is still held.
    if (!rst_n) begin
      m_read     = 1'b0;
      m_write    = 1'b0;
      own_wait   = 1'b1;
      rdv_own    = 1'b0;
      stray_beat = 1'b0;
    end
  end

  assign h0_waitrequest   = owner ? 1'b1 : own_wait;
  assign h1_waitrequest   = owner ? own_wait : 1'b1;
  assign h0_readdatavalid = rdv_own & ~owner;
  assign h1_readdatavalid = rdv_own & owner;
  assign h0_readdata      = m_readdata;
  assign h1_readdata      = m_readdata;

endmodule

// File: doc/avalon_rd_wr_arbiter.md
Name: avalon_rd_wr_arbiter

Overview:
- Shares one Avalon-MM SDRAM agent port between two hosts.
- Host 0 is the video framebuffer reader: high priority, read bursts.
- Host 1 is the pixel/drawing writer: low priority, read or write bursts.
- Grants whole bursts atomically, routes returning read beats to the owning host, and prevents host-1 starvation. Sits between the hosts and the SDRAM controller, in the SDRAM clock domain.

Parameters:
- ADDR_W, 32, address width (byte address).
- DATA_W, 32, data width; byteenable width BE_W = DATA_W/8.
- BURST_W, 6, burstcount width.
- STARVE_LIMIT, 4, consecutive host-0 grants allowed while host 1 is pending before host 1 is forced.

Ports:
- clk  in  1  single clock, SDRAM/Avalon domain.
- rst_n  in  1  synchronous, active-low reset.
- hN_address  in  ADDR_W  host N address (N = 0, 1).
- hN_read, hN_write  in  1  host N command.
- hN_writedata  in  DATA_W  host N write data.
- hN_byteenable  in  BE_W  host N byte enables.
- hN_burstcount  in  BURST_W  host N burst length.
- hN_waitrequest  out  1  stall to host N.
- hN_readdata  out  DATA_W  read data, a copy of m_readdata.
- hN_readdatavalid  out  1  read beat valid for host N.
- m_address, m_writedata, m_byteenable, m_burstcount  out  ADDR_W/DATA_W/BE_W/BURST_W  to the agent.
- m_read, m_write  out  1  command to the agent.
- m_waitrequest, m_readdatavalid  in  1  from the agent.
- m_readdata  in  DATA_W  from the agent.
- stray_beat  out  1  one-cycle pulse on an unexpected readdatavalid.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, owner=0, beat counter=0, starvation counter=0.
  - m_read=m_write=0; both hN_waitrequest=1; both hN_readdatavalid=0; stray_beat=0.
- States: IDLE, CMD, RD_DATA, WR_DATA.
- IDLE:
  - All hN_waitrequest=1; m_read=m_write=0.
  - Request = hN_read | hN_write.
  - Arbitration: host 0 wins if requesting, unless host 1 is requesting and the starvation counter equals STARVE_LIMIT.
  - Latch owner, go to CMD next cycle. Grant latency is 1 cycle.
  - Starvation counter: increments on a host-0 grant while h1 is requesting; clears on any host-1 grant or when h1 is idle.
- CMD:
  - m_* driven combinationally from the owner's signals.
  - Owner waitrequest = m_waitrequest; non-owner waitrequest = 1.
  - If owner's read and write are both low, return to IDLE.
  - Read accepted (m_read & !m_waitrequest): load beat counter with burstcount, go to RD_DATA.
  - Write accepted: load beat counter with burstcount-1 (first beat consumed). If the result is 0, go to IDLE; else go to WR_DATA.
  - Read and write both high: read takes precedence; write is masked.
  - Burstcount 0 is treated as 1.
- RD_DATA:
  - m_read=m_write=0; both waitrequests=1.
  - Each m_readdatavalid asserts the owner's readdatavalid in the same cycle (combinational) and decrements the counter.
  - On the beat where counter==1, go to IDLE.
- WR_DATA:
  - m_write/m_writedata/m_byteenable pass from the owner; m_address and m_burstcount held at the first-beat values.
  - Each accepted beat decrements the counter; at 1, go to IDLE after acceptance.
  - Owner deasserting write mid-burst stalls; the burst is not abandoned.
- m_readdatavalid outside RD_DATA:
  - Not forwarded to either host.
  - stray_beat pulses for 1 cycle. This covers beats still returning after a reset mid-burst.
- hN_readdata = m_readdata always; validity is qualified only by hN_readdatavalid.
- Back-to-back: minimum one IDLE cycle between bursts, so burst n+1's command is issued ≥1 cycle after burst n's last beat.
- Reset mid-operation: returns to IDLE immediately; the in-flight burst is lost; hosts must reissue.

Test Plan:
1. Reset, then h0_read burstcount=16 addr=0x40; agent waitrequest=0, 16 beats of 0..15 → one m_read at addr 0x40 with burst 16; h0_readdatavalid×16 with data 0..15; h1_readdatavalid never set; return to IDLE.
2. h0 and h1 both requesting continuously, bursts of 4 → grant order h0,h0,h0,h0,h1,h0,h0,h0,h0,h1 (STARVE_LIMIT=4).
3. h1_write burst 8, agent waitrequest toggled every other cycle, h1_write dropped for 2 cycles mid-burst → exactly 8 m_write acceptances; address and burstcount constant; h0_read requested meanwhile waits until burst end+1 cycle.
4. h0 read burst 16 in progress, rst_n low at beat 5, agent returns 11 more beats → no hN_readdatavalid; stray_beat pulses 11 times; m_read stays 0 until a new request.
5. h1 asserts read and write with burstcount=0 → a single read command of burst 0 passed through, counter treats it as 1 beat; one readdatavalid to h1; return to IDLE.
